// File: rtl/taximeter_pkg.sv
// taximeter_pkg: state encoding, fare defaults and display limits
// shared by the taximeter core and its saturating counters.
package taximeter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam int BASE_FARE_DEF = 10;
  localparam int BASE_KM_DEF   = 3;
  localparam int KM_RATE_DEF   = 2;
  localparam int WAIT_RATE_DEF = 1;

  localparam int MIL_MAX  = 99;
  localparam int TIME_MAX = 59;
  localparam int COST_MAX = 999;

endpackage

// File: rtl/taximeter_satcnt.sv
// taximeter_satcnt: saturating accumulator with clear, load and
// a one-bit-wider sum so overflow past MAX clamps exactly to MAX.
module taximeter_satcnt
  import taximeter_pkg::*;
#(
  parameter int W   = 8,
  parameter int MAX = MIL_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] inc,
  output logic [W-1:0] q
);

  logic [W:0] sum;

  assign sum = {1'b0, q} + {1'b0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
    end
  end

endmodule

// File: rtl/taximeter_core.sv
// taximeter_core: trip FSM with command priority decode, driving
// saturating counters for distance, waiting time and fare.
module taximeter_core
  import taximeter_pkg::*;
#(
  parameter int BASE_FARE = BASE_FARE_DEF,
  parameter int BASE_KM   = BASE_KM_DEF,
  parameter int KM_RATE   = KM_RATE_DEF,
  parameter int WAIT_RATE = WAIT_RATE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        km_pulse,
  input  logic        tick_min,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        clear,
  output logic [7:0]  mil,
  output logic [6:0]  timee,
  output logic [10:0] cost,
  output logic [1:0]  state
);

  logic   rst_q1, rst_q2;
  state_t st, st_nx;
  logic   c_clr, c_stp, c_pse, c_srt;
  logic   any_cmd, ld;
  logic   km_en, tk_en, fare_en;
  logic   mil_room, past_base;
  logic [10:0] fare_inc;

  // assert asynchronously, release two edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rst_q2, rst_q1} <= 2'b00;
    end else begin
      {rst_q2, rst_q1} <= {rst_q1, 1'b1};
    end
  end

  assign c_clr   = clear;
  assign c_stp   = stop & ~clear;
  assign c_pse   = pause & ~stop & ~clear;
  assign c_srt   = start & ~pause & ~stop & ~clear;
  assign any_cmd = start | pause | stop | clear;

  always_ff @(posedge clk or negedge rst_q2) begin
    if (!rst_q2) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx = st;
    ld    = 1'b0;
    unique case (1'b1)
      c_clr: st_nx = IDLE;
      c_stp: if (st == RUN || st == WAIT) st_nx = STOP;
      c_pse: if (st == RUN) st_nx = WAIT;
      c_srt: begin
        if (st == IDLE || st == STOP) begin
          st_nx = RUN;
          ld    = 1'b1;
        end else if (st == WAIT) begin
          st_nx = RUN;
        end
      end
      default: ;
    endcase
  end

  // any command pulse swallows a coincident km/minute event
  assign km_en     = (st == RUN) & km_pulse & ~any_cmd;
  assign tk_en     = (st == WAIT) & tick_min & ~any_cmd;
  assign mil_room  = mil < 8'(MIL_MAX);
  assign past_base = (int'(mil) + 1) > BASE_KM;
  assign fare_en   = (km_en & mil_room & past_base) | tk_en;
  assign fare_inc  = tk_en ? 11'(WAIT_RATE) : 11'(KM_RATE);
  assign state     = st;

  taximeter_satcnt #(.W(8), .MAX(MIL_MAX)) u_mil (
    .clk      (clk),
    .rst_n    (rst_q2),
    .clr      (c_clr),
    .load     (ld),
    .en       (km_en),
    .load_val (8'd0),
    .inc      (8'd1),
    .q        (mil)
  );

  taximeter_satcnt #(.W(7), .MAX(TIME_MAX)) u_time (
    .clk      (clk),
    .rst_n    (rst_q2),
    .clr      (c_clr),
    .load     (ld),
    .en       (tk_en),
    .load_val (7'd0),
    .inc      (7'd1),
    .q        (timee)
  );

  taximeter_satcnt #(.W(11), .MAX(COST_MAX)) u_cost (
    .clk      (clk),
    .rst_n    (rst_q2),
    .clr      (c_clr),
    .load     (ld),
    .en       (fare_en),
    .load_val (11'(BASE_FARE)),
    .inc      (fare_inc),
    .q        (cost)
  );

endmodule

// File: tb/tb_taximeter_core.sv
// tb_taximeter_core: random and directed trips checked every cycle
// against a behavioural fare model, plus literal scenario results.
module tb_taximeter_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        km_pulse = 1'b0;
  logic        tick_min = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  mil;
  logic [6:0]  timee;
  logic [10:0] cost;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int ms = 0, mm = 0, mt = 0, mc = 0;
  int since = 0;

  taximeter_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .km_pulse (km_pulse),
    .tick_min (tick_min),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .clear    (clear),
    .mil      (mil),
    .timee    (timee),
    .cost     (cost),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cap(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_zero();
    ms = 0; mm = 0; mt = 0; mc = 0;
  endtask

  // fare rules: 0=idle 1=run 2=wait 3=stop
  task automatic model_step();
    if (!rst_n) begin
      model_zero();
      since = 0;
    end else if (since < 2) begin
      since++;
    end else if (clear) begin
      model_zero();
    end else if (stop) begin
      if (ms == 1 || ms == 2) ms = 3;
    end else if (pause) begin
      if (ms == 1) ms = 2;
    end else if (start) begin
      if (ms == 0 || ms == 3) begin
        ms = 1; mm = 0; mt = 0; mc = 10;
      end else if (ms == 2) begin
        ms = 1;
      end
    end else if (ms == 1 && km_pulse) begin
      if (mm < 99) begin
        mm++;
        if (mm > 3) mc = cap(mc + 2, 999);
      end
    end else if (ms == 2 && tick_min) begin
      mt = cap(mt + 1, 59);
      mc = cap(mc + 1, 999);
    end
  endtask

  task automatic cyc(input bit km, input bit tk, input bit st,
                     input bit pa, input bit sp, input bit cl);
    km_pulse = km; tick_min = tk;
    start = st; pause = pa; stop = sp; clear = cl;
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_state", int'(state), ms);
      chk("cmp_mil", int'(mil), mm);
      chk("cmp_timee", int'(timee), mt);
      chk("cmp_cost", int'(cost), mc);
    end
  end

  task automatic rand_run(input int n, input int cdiv);
    bit km, tk, st, pa, sp, cl;
    for (int i = 0; i < n; i++) begin
      km = ($urandom_range(0, 2) == 0);
      tk = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, cdiv) == 0);
      pa = ($urandom_range(0, cdiv + 10) == 0);
      sp = ($urandom_range(0, 2 * cdiv) == 0);
      cl = ($urandom_range(0, 6 * cdiv) == 0);
      cyc(km, tk, st, pa, sp, cl);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_mil", int'(mil), 0);
    chk("rst_timee", int'(timee), 0);
    chk("rst_cost", int'(cost), 0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    since = 0;
    cyc(0, 0, 1, 0, 0, 0);
    chk("sync_hold", int'(state), 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    cyc(0, 0, 1, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 0);
    chk("s1_state", int'(state), 1);
    chk("s1_mil", int'(mil), 5);
    chk("s1_cost", int'(cost), 14);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s2_state", int'(state), 3);
    chk("s2_mil", int'(mil), 2);
    chk("s2_timee", int'(timee), 3);
    chk("s2_cost", int'(cost), 13);
    repeat (4) cyc(1, 1, 0, 0, 0, 0);
    chk("s2_frz_mil", int'(mil), 2);
    chk("s2_frz_timee", int'(timee), 3);
    chk("s2_frz_cost", int'(cost), 13);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (120) cyc(1, 0, 0, 0, 0, 0);
    chk("s3_mil", int'(mil), 99);
    chk("s3_cost", int'(cost), 202);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s3_sat_mil", int'(mil), 99);
    chk("s3_sat_cost", int'(cost), 202);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (1000) cyc(0, 1, 0, 0, 0, 0);
    chk("s4_state", int'(state), 2);
    chk("s4_timee", int'(timee), 59);
    chk("s4_cost", int'(cost), 999);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 1);
    chk("s5_state", int'(state), 0);
    chk("s5_mil", int'(mil), 0);
    chk("s5_cost", int'(cost), 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("s5_wait_state", int'(state), 2);
    chk("s5_wait_mil", int'(mil), 1);

    repeat (2) cyc(0, 1, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    model_zero();
    since = 0;
    #1;
    chk("s6_async_state", int'(state), 0);
    chk("s6_async_timee", int'(timee), 0);
    chk("s6_async_cost", int'(cost), 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0, 0);
    chk("s6_sync_hold", int'(state), 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("s6_state", int'(state), 1);
    chk("s6_cost", int'(cost), 10);

    rand_run(3000, 20);
    rand_run(3000, 400);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
